// File: rtl/usb_pkg.sv
// Shared encodings for the full-speed USB receive path.
package usb_pkg;

  // Line-state encodings: bit 0 is D+, bit 1 is D-.
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  // clock48 cycles per full-speed bit.
  localparam int unsigned FS_OVERSAMPLE = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StEop,
    StAbort
  } rx_state_e;

endpackage

// File: rtl/usb_dpll.sv
// Pin synchronizer plus a small DPLL that picks one sample point per bit.
module usb_dpll
  import usb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       usb_d_p_i,
  input  logic       usb_d_n_i,
  output logic [1:0] line_state_o,
  output logic       sample_o
);

  localparam int unsigned PhaseW = $clog2(FS_OVERSAMPLE);
  localparam logic [PhaseW-1:0] SamplePhase = PhaseW'(FS_OVERSAMPLE / 2);

  logic [1:0]        meta_q, sync_q, prev_q;
  logic [PhaseW-1:0] phase_q, phase_cur;

  // Two-flop synchronizer, a delayed copy for edge detect, and the phase counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= LS_J;
      sync_q  <= LS_J;
      prev_q  <= LS_J;
      phase_q <= '0;
    end else begin
      meta_q  <= {usb_d_n_i, usb_d_p_i};
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      phase_q <= phase_cur + 1'b1;
    end
  end

  // A line transition realigns the phase so the sample lands mid-bit.
  always_comb begin
    phase_cur = phase_q;
    if (sync_q != prev_q) phase_cur = '0;
  end

  assign sample_o     = (phase_cur == SamplePhase);
  assign line_state_o = sync_q;

endmodule

// File: rtl/usb_rx_frontend.sv
// Full-speed USB receive front end: NRZI decode, SYNC/EOP framing, bit unstuffing, bus reset.
module usb_rx_frontend
  import usb_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 120,
  parameter int unsigned STUFF_LIMIT  = 6
) (
  input  logic       clock48,
  input  logic       reset_n,
  input  logic       usb_d_p,
  input  logic       usb_d_n,
  input  logic       rx_enable,
  output logic [1:0] line_state,
  output logic       bus_reset,
  output logic       rx_active,
  output logic       packet_start,
  output logic       bit_valid,
  output logic       bit_data,
  output logic       packet_end,
  output logic       rx_error
);

  localparam logic [8:0] ResetThresh  = 9'(RESET_CYCLES);
  localparam logic [2:0] StuffLimit   = 3'(STUFF_LIMIT);
  localparam logic [2:0] SyncMinZeros = 3'd5;

  logic [1:0] ls;
  logic       sample;

  usb_dpll u_dpll (
    .clk_i       (clock48),
    .rst_ni      (reset_n),
    .usb_d_p_i   (usb_d_p),
    .usb_d_n_i   (usb_d_n),
    .line_state_o(ls),
    .sample_o    (sample)
  );

  assign line_state = ls;

  logic [8:0] se0_cnt_q, se0_cnt_d;
  logic       bus_reset_q;

  // Saturating count of consecutive SE0 cycles.
  always_comb begin
    se0_cnt_d = '0;
    if (ls == LS_SE0) se0_cnt_d = (se0_cnt_q == '1) ? se0_cnt_q : se0_cnt_q + 9'd1;
  end

  // Bus reset tracking, independent of rx_enable.
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      se0_cnt_q   <= '0;
      bus_reset_q <= 1'b0;
    end else begin
      se0_cnt_q   <= se0_cnt_d;
      bus_reset_q <= (se0_cnt_d >= ResetThresh);
    end
  end

  assign bus_reset = bus_reset_q;

  rx_state_e  state_q, state_d;
  logic [2:0] zero_q, zero_d, ones_q, ones_d;
  logic       prev_k_q, prev_k_d;
  logic       start_d, valid_d, data_d, end_d, err_d;
  logic       is_j, is_k, is_se0, is_jk, dec;

  assign is_j   = (ls == LS_J);
  assign is_k   = (ls == LS_K);
  assign is_se0 = (ls == LS_SE0);
  assign is_jk  = is_j | is_k;
  // NRZI: no transition decodes as 1.
  assign dec    = (is_k == prev_k_q);

  // Receive FSM: next state, counters and strobes, evaluated on sample points.
  always_comb begin
    state_d  = state_q;
    zero_d   = zero_q;
    ones_d   = ones_q;
    prev_k_d = prev_k_q;
    start_d  = 1'b0;
    valid_d  = 1'b0;
    data_d   = 1'b0;
    end_d    = 1'b0;
    err_d    = 1'b0;
    if (!rx_enable) begin
      state_d = StIdle;
    end else if (sample) begin
      unique case (state_q)
        StIdle: begin
          if (is_k) begin
            // The first SYNC K is already decoded as a 0 against J.
            zero_d   = 3'd1;
            prev_k_d = 1'b1;
            state_d  = StSync;
          end
        end
        StSync: begin
          if (is_jk) begin
            prev_k_d = is_k;
            if (!dec) begin
              if (zero_q != 3'd7) zero_d = zero_q + 3'd1;
            end else if (zero_q >= SyncMinZeros) begin
              start_d = 1'b1;
              ones_d  = '0;
              state_d = StData;
            end else begin
              state_d = StIdle;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StData: begin
          if (is_jk) begin
            prev_k_d = is_k;
            if (ones_q == StuffLimit) begin
              if (dec) begin
                err_d   = 1'b1;
                state_d = StAbort;
              end else begin
                ones_d = '0;
              end
            end else begin
              valid_d = 1'b1;
              data_d  = dec;
              ones_d  = dec ? ones_q + 3'd1 : 3'd0;
            end
          end else if (is_se0) begin
            state_d = StEop;
          end else begin
            err_d   = 1'b1;
            state_d = StAbort;
          end
        end
        StEop: begin
          if (is_j) begin
            end_d   = 1'b1;
            state_d = StIdle;
          end else if (!is_se0) begin
            err_d   = 1'b1;
            state_d = StAbort;
          end
        end
        StAbort: begin
          if (is_j) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      zero_q       <= '0;
      ones_q       <= '0;
      prev_k_q     <= 1'b0;
      packet_start <= 1'b0;
      bit_valid    <= 1'b0;
      bit_data     <= 1'b0;
      packet_end   <= 1'b0;
      rx_error     <= 1'b0;
      rx_active    <= 1'b0;
    end else begin
      state_q      <= state_d;
      zero_q       <= zero_d;
      ones_q       <= ones_d;
      prev_k_q     <= prev_k_d;
      packet_start <= start_d;
      bit_valid    <= valid_d;
      bit_data     <= data_d;
      packet_end   <= end_d;
      rx_error     <= err_d;
      rx_active    <= (state_d == StData) || (state_d == StEop);
    end
  end

endmodule

// File: tb/tb_usb_rx_frontend.sv
// Scoreboard bench for usb_rx_frontend: line-level packet encoder plus event monitor.
module tb_usb_rx_frontend;

  localparam logic [1:0] J = 2'b01;
  localparam logic [1:0] K = 2'b10;
  localparam logic [1:0] SE0 = 2'b00;

  // Event codes: 0 start, 2 bit0, 3 bit1, 4 end, 5 error.
  localparam int EvStart = 0;
  localparam int EvEnd = 4;
  localparam int EvErr = 5;

  logic       clock48 = 1'b0;
  logic       reset_n = 1'b0;
  logic       usb_d_p = 1'b1;
  logic       usb_d_n = 1'b0;
  logic       rx_enable = 1'b1;
  logic [1:0] line_state;
  logic       bus_reset, rx_active, packet_start, bit_valid, bit_data, packet_end, rx_error;

  usb_rx_frontend dut (
    .clock48     (clock48),
    .reset_n     (reset_n),
    .usb_d_p     (usb_d_p),
    .usb_d_n     (usb_d_n),
    .rx_enable   (rx_enable),
    .line_state  (line_state),
    .bus_reset   (bus_reset),
    .rx_active   (rx_active),
    .packet_start(packet_start),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .packet_end  (packet_end),
    .rx_error    (rx_error)
  );

  always #10 clock48 = ~clock48;

  int total = 0;
  int bad = 0;
  int sb[$];
  logic [1:0] sym[$];
  logic [1:0] lvl;
  int ones;
  int bv_count = 0;
  int bus_hi_cnt = 0;
  logic [1:0] bus_hi_ls = 2'b11;
  int base;
  int guard;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic got(input int ev);
    int exp;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got %0d with nothing expected", ev);
    end else begin
      exp = sb.pop_front();
      check("event", ev, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT strobes something.
  always @(negedge clock48) begin
    if (reset_n) begin
      if (packet_start) got(EvStart);
      if (bit_valid) begin
        got(2 + int'(bit_data));
        bv_count++;
      end
      if (packet_end) got(EvEnd);
      if (rx_error) begin
        got(EvErr);
        check("rx_active_on_error", rx_active, 0);
      end
      if (bus_reset) begin
        bus_hi_cnt++;
        bus_hi_ls = line_state;
      end
    end
  end

  task automatic put_bit(input bit v);
    if (!v) lvl = (lvl == J) ? K : J;
    sym.push_back(lvl);
  endtask

  task automatic put_data(input bit v);
    put_bit(v);
    ones = v ? ones + 1 : 0;
    if (ones == 6) begin
      put_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic start_pkt();
    sym.delete();
    lvl = J;
    for (int i = 0; i < 7; i++) put_bit(1'b0);
    put_bit(1'b1);
    ones = 0;
    sb.push_back(EvStart);
  endtask

  task automatic byte_out(input logic [7:0] b, input bit push);
    for (int i = 0; i < 8; i++) begin
      put_data(b[i]);
      if (push) sb.push_back(2 + int'(b[i]));
    end
  endtask

  task automatic eop(input bit push);
    sym.push_back(SE0);
    sym.push_back(SE0);
    sym.push_back(J);
    if (push) sb.push_back(EvEnd);
  endtask

  task automatic set_line(input logic [1:0] l);
    usb_d_p = l[0];
    usb_d_n = l[1];
  endtask

  // Drive symbol runs; with jitter each run is stretched/shrunk by one cycle alternately.
  task automatic drive(input bit jitter);
    int i, n, cycles, jt;
    i = 0;
    jt = 1;
    @(posedge clock48);
    while (i < sym.size()) begin
      n = 1;
      while (i + n < sym.size() && sym[i+n] == sym[i]) n++;
      #2 set_line(sym[i]);
      cycles = 4 * n;
      if (jitter) begin
        cycles += jt;
        jt = -jt;
      end
      repeat (cycles) @(posedge clock48);
      i += n;
    end
    #2 set_line(J);
    repeat (20) @(posedge clock48);
  endtask

  task automatic drain(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic se0_for(input int n, input int exp_hi);
    bus_hi_cnt = 0;
    bus_hi_ls = 2'b11;
    @(posedge clock48);
    #2 set_line(SE0);
    repeat (n) @(posedge clock48);
    #2 set_line(J);
    repeat (10) @(posedge clock48);
    check("bus_reset_high_cycles", bus_hi_cnt, exp_hi);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock48);
    reset_n = 1'b1;
    @(posedge clock48);
    #1;
    check("reset_line_state", line_state, 2'b01);
    check("reset_outputs",
          {bus_reset, rx_active, packet_start, bit_valid, bit_data, packet_end, rx_error}, 0);
    repeat (10) @(posedge clock48);

    // SYNC + 8'hA5 + EOP, bits hand-listed LSB first.
    start_pkt();
    byte_out(8'hA5, 1'b0);
    sb.push_back(3); sb.push_back(2); sb.push_back(3); sb.push_back(2);
    sb.push_back(2); sb.push_back(3); sb.push_back(2); sb.push_back(3);
    eop(1'b1);
    drive(1'b0);
    drain("a5_all_events_seen");

    // 8'hFF: one stuff bit on the wire, eight ones delivered, no error.
    start_pkt();
    byte_out(8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) sb.push_back(3);
    eop(1'b1);
    drive(1'b0);
    drain("ff_all_events_seen");

    // Seven ones without a stuff bit: six data bits then an error, no packet_end.
    start_pkt();
    for (int i = 0; i < 7; i++) put_bit(1'b1);
    for (int i = 0; i < 6; i++) sb.push_back(3);
    sb.push_back(EvErr);
    eop(1'b0);
    drive(1'b0);
    drain("stuff_err_events_seen");
    check("stuff_err_rx_active_after", rx_active, 0);

    // 64-bit packet with edge jitter.
    start_pkt();
    byte_out(8'h3C, 1'b1);
    byte_out(8'hFF, 1'b1);
    byte_out(8'h00, 1'b1);
    byte_out(8'h5A, 1'b1);
    byte_out(8'hC3, 1'b1);
    byte_out(8'h7E, 1'b1);
    byte_out(8'h81, 1'b1);
    byte_out(8'hE7, 1'b1);
    eop(1'b1);
    drive(1'b1);
    drain("jitter_all_events_seen");

    // Pin-to-line_state latency is two cycles.
    @(posedge clock48);
    #2 set_line(SE0);
    @(posedge clock48);
    #1 check("latency_after_1", line_state, J);
    @(posedge clock48);
    #1 check("latency_after_2", line_state, SE0);
    #1 set_line(J);
    repeat (200) @(posedge clock48);

    se0_for(119, 0);
    se0_for(120, 1);
    check("bus_reset_clears_after_j", bus_hi_ls, J);
    se0_for(125, 6);
    drain("bus_reset_no_events");

    // rx_enable dropped after the fourth data bit.
    start_pkt();
    byte_out(8'h5A, 1'b1);
    byte_out(8'h3C, 1'b1);
    eop(1'b1);
    while (sb.size() > 5) void'(sb.pop_back());
    base = bv_count;
    fork
      drive(1'b0);
      begin
        guard = 0;
        while (bv_count < base + 4 && guard < 4000) begin
          @(negedge clock48);
          #1;
          guard++;
        end
        check("rxen_bits_before_drop", bv_count - base, 4);
        check("rxen_active_before_drop", rx_active, 1);
        @(posedge clock48);
        #1 rx_enable = 1'b0;
        @(posedge clock48);
        #1 check("rxen_active_next_cycle", rx_active, 0);
      end
    join
    rx_enable = 1'b1;
    repeat (10) @(posedge clock48);
    drain("rxen_events");

    // Asynchronous reset after the second data bit.
    start_pkt();
    byte_out(8'h96, 1'b1);
    eop(1'b1);
    while (sb.size() > 3) void'(sb.pop_back());
    base = bv_count;
    fork
      drive(1'b0);
      begin
        guard = 0;
        while (bv_count < base + 2 && guard < 4000) begin
          @(negedge clock48);
          #1;
          guard++;
        end
        check("arst_bits_before_reset", bv_count - base, 2);
        @(posedge clock48);
        #5 reset_n = 1'b0;
        #1;
        check("arst_line_state", line_state, 2'b01);
        check("arst_outputs",
              {bus_reset, rx_active, packet_start, bit_valid, bit_data, packet_end, rx_error}, 0);
      end
    join
    @(negedge clock48);
    reset_n = 1'b1;
    repeat (10) @(posedge clock48);
    drain("arst_events");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
